// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
//
// Instruction-fetch stage plus the IF/ID pipeline register of the MIPS core.
// This block owns the program counter. It requests instruction words from
// instruction memory over a ready handshake and hands them to Decode. Taken
// branches and jumps resolved in Decode redirect the PC with delay-slot
// semantics: the word already being fetched (branch+4) always enters Decode.
//
// Ports
//   clk, rst_n            core clock, asynchronous active-low reset
//   StallF, StallD        hazard-unit enables (1 = advance); both must be 1
//   PCSrcD, PCBranchD     taken branch and its target, from Decode
//   JumpD, PCJumpD        jump and its target, from Decode (wins over branch)
//   imem_req, imem_addr   fetch request and its address (= PCF)
//   imem_ready, imem_rdata  response strobe and instruction word; may be
//                         combinational in the same cycle as the request
//   PCF                   current fetch PC
//   InstrD, PCPlus4D      IF/ID instruction and its PC+4
//   ValidD                InstrD holds a real instruction (0 = bubble)
// -----------------------------------------------------------------------------
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        StallF,
    input  logic        StallD,
    input  logic        PCSrcD,
    input  logic [31:0] PCBranchD,
    input  logic        JumpD,
    input  logic [31:0] PCJumpD,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    output logic [31:0] PCF,
    output logic [31:0] InstrD,
    output logic [31:0] PCPlus4D,
    output logic        ValidD
);

    // F_REQ:  a request for PCF is outstanding.
    // F_HELD: the word for PCF has arrived but Decode could not take it yet.
    typedef enum logic {
        F_REQ  = 1'b0,
        F_HELD = 1'b1
    } fetchState_t;

    fetchState_t state;
    fetchState_t nextState;

    logic        advance;
    logic        qualJump;
    logic        qualBranch;
    logic        qualRedirect;
    logic [31:0] redirectTarget;
    logic [31:0] pcPlus4F;
    logic [31:0] nextPc;

    logic        redirectPending;
    logic [31:0] redirectPc;
    logic [31:0] holdBuf;

    // The hazard unit only ever means "go" when both enables agree.
    assign advance = StallF & StallD;

    // Redirects only count when Decode holds a real instruction.
    assign qualJump       = JumpD & ValidD;
    assign qualBranch     = PCSrcD & ValidD;
    assign qualRedirect   = qualJump | qualBranch;
    assign redirectTarget = (qualJump ? PCJumpD : PCBranchD) & 32'hFFFF_FFFC;

    assign pcPlus4F = PCF + 32'd4;

    // A redirect captured while imem was stalling is older than anything
    // Decode shows now (Decode holds a bubble), so it goes first.
    assign nextPc = redirectPending ? redirectPc :
                    qualRedirect    ? redirectTarget :
                                      pcPlus4F;

    assign imem_addr = PCF;

    // ---------------------------------------------------------------- FSM --
    // NOTE: registers use non-blocking assignments so every flop samples the
    // pre-edge values, independent of the order of statements or blocks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= F_REQ;
        end else begin
            state <= nextState;
        end
    end

    // NOTE: each combinational output gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        nextState = state;
        case (state)
            F_REQ:   if (imem_ready && !advance) nextState = F_HELD;
            F_HELD:  if (advance)                nextState = F_REQ;
            default: nextState = F_REQ;
        endcase
    end

    // The request is squashed while reset is asserted, even though the reset
    // state is F_REQ.
    always_comb begin
        imem_req = 1'b0;
        if (rst_n && state == F_REQ) imem_req = 1'b1;
    end

    // ----------------------------------------------------------- datapath --
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            PCF             <= RESET_PC;
            InstrD          <= 32'd0;
            PCPlus4D        <= 32'd0;
            ValidD          <= 1'b0;
            redirectPending <= 1'b0;
            redirectPc      <= 32'd0;
            holdBuf         <= 32'd0;
        end else begin
            case (state)
                F_REQ: begin
                    if (imem_ready) begin
                        if (advance) begin
                            InstrD          <= imem_rdata;
                            PCPlus4D        <= pcPlus4F;
                            ValidD          <= 1'b1;
                            PCF             <= nextPc;
                            redirectPending <= 1'b0;
                        end else begin
                            // Park the word; PCF and IF/ID stay put.
                            holdBuf <= imem_rdata;
                        end
                    end else if (advance) begin
                        // Decode moves on but nothing arrived: insert a
                        // bubble. The branch leaving Decode must not be lost,
                        // so its target is remembered for the delay slot.
                        InstrD <= 32'd0;
                        ValidD <= 1'b0;
                        if (qualRedirect && !redirectPending) begin
                            redirectPending <= 1'b1;
                            redirectPc      <= redirectTarget;
                        end
                    end
                end
                F_HELD: begin
                    if (advance) begin
                        InstrD          <= holdBuf;
                        PCPlus4D        <= pcPlus4F;
                        ValidD          <= 1'b1;
                        PCF             <= nextPc;
                        redirectPending <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_fetch_stage
//
// Random-stimulus bench for fetch_stage. Instruction memory is a pure function
// of the address. Each word also encodes what Decode does with it (branch,
// jump, both, or nothing, plus targets), so the bench can act as Decode.
//
// The reference model runs that "program" at instruction level with MIPS
// delay-slot rules. Each fetched PC follows from the instruction two slots
// earlier, or from PC+4. The model produces the expected order of fetch
// addresses and of instructions entering Decode. A monitor process compares
// each memory acceptance and each Decode load against those queues. It also
// checks bubble, hold, F_HELD and address-stability behaviour cycle by cycle.
// -----------------------------------------------------------------------------
module tb_fetch_stage;

    localparam logic [31:0] RESET_PC = 32'h0040_0000;
    localparam int          MODEL_LEN = 3000;
    localparam int          RUN_CYCLES = 3000;

    logic        clk;
    logic        rst_n;
    logic        StallF, StallD;
    logic        PCSrcD, JumpD;
    logic [31:0] PCBranchD, PCJumpD;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic [31:0] PCF, InstrD, PCPlus4D;
    logic        ValidD;

    int checks = 0;
    int errors = 0;
    int delivered = 0;
    int gen = 0;

    logic [31:0] exp_fetch[$];
    logic [31:0] exp_deliv[$];

    fetch_stage #(.RESET_PC(RESET_PC)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .StallF     (StallF),
        .StallD     (StallD),
        .PCSrcD     (PCSrcD),
        .PCBranchD  (PCBranchD),
        .JumpD      (JumpD),
        .PCJumpD    (PCJumpD),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ready (imem_ready),
        .imem_rdata (imem_rdata),
        .PCF        (PCF),
        .InstrD     (InstrD),
        .PCPlus4D   (PCPlus4D),
        .ValidD     (ValidD)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ------------------------------------------------------------ program --
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        logic [31:0] x;
        x = a ^ 32'hA5A5_1234;
        x = x * 32'h9E37_79B1;
        x = x ^ (x >> 16);
        x = x * 32'h85EB_CA6B;
        x = x ^ (x >> 13);
        return x;
    endfunction

    // Low nibble selects the Decode behaviour: 0-2 branch, 3 branch+jump,
    // 4 jump, anything else falls through.
    function automatic logic is_branch(input logic [31:0] w);
        return w[3:0] <= 4'd3;
    endfunction

    function automatic logic is_jump(input logic [31:0] w);
        return (w[3:0] == 4'd3) || (w[3:0] == 4'd4);
    endfunction

    function automatic logic [31:0] branch_tgt(input logic [31:0] w);
        return {16'h0040, w[31:16]};
    endfunction

    function automatic logic [31:0] jump_tgt(input logic [31:0] w);
        return {8'h00, w[31:8]};
    endfunction

    assign imem_rdata = imem_ready ? mem_word(imem_addr) : 32'hDEAD_BEEF;

    // Instruction-level model: slot k+1 is steered by the instruction in
    // slot k-1 (slot k is its delay slot). Fetch order and Decode order are
    // the same stream.
    task automatic refill_model();
        logic [31:0] a, b, n, w;
        exp_fetch.delete();
        exp_deliv.delete();
        a = RESET_PC;
        b = RESET_PC + 32'd4;
        exp_fetch.push_back(a);
        exp_deliv.push_back(a);
        for (int k = 1; k < MODEL_LEN; k++) begin
            exp_fetch.push_back(b);
            exp_deliv.push_back(b);
            w = mem_word(a);
            if (is_jump(w))        n = jump_tgt(w) & ~32'd3;
            else if (is_branch(w)) n = branch_tgt(w) & ~32'd3;
            else                   n = b + 32'd4;
            a = b;
            b = n;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------ drivers --
    task automatic drive_random();
        if ($urandom_range(0, 99) < 75) begin
            StallF = 1'b1;
            StallD = 1'b1;
        end else begin
            StallF = 1'($urandom_range(0, 1));
            StallD = 1'($urandom_range(0, 1));
        end
        imem_ready = ($urandom_range(0, 99) < 70);
        if (ValidD) begin
            PCSrcD    = is_branch(InstrD);
            JumpD     = is_jump(InstrD);
            PCBranchD = branch_tgt(InstrD);
            PCJumpD   = jump_tgt(InstrD);
        end else begin
            // Decode holds a bubble: garbage here must be ignored.
            PCSrcD    = 1'($urandom_range(0, 1));
            JumpD     = 1'($urandom_range(0, 1));
            PCBranchD = $urandom;
            PCJumpD   = $urandom;
        end
    endtask

    task automatic release_reset();
        refill_model();
        rst_n = 1'b1;
        #1;
        check("req_after_reset", 32'(imem_req), 32'd1);
        check("addr_after_reset", imem_addr, RESET_PC);
    endtask

    // Steer the DUT into F_HELD, then reset it asynchronously mid-cycle.
    task automatic reset_in_held();
        logic found;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            @(negedge clk);
            StallF     = 1'b0;
            StallD     = 1'b0;
            imem_ready = 1'b1;
            #1;
            if (!imem_req) found = 1'b1;
        end
        check("reached_held", 32'(found), 32'd1);
        #2;
        rst_n = 1'b0;
        gen++;
        #1;
        check("rst_pcf", PCF, RESET_PC);
        check("rst_validd", 32'(ValidD), 32'd0);
        check("rst_instrd", InstrD, 32'd0);
        check("rst_req", 32'(imem_req), 32'd0);
        repeat (2) @(negedge clk);
        release_reset();
    endtask

    // ------------------------------------------------------------ monitor --
    initial begin
        logic        p_req, p_rdy, p_adv;
        logic [31:0] p_addr, p_instr, p_p4, pc;
        logic        p_valid;
        int          g;
        forever begin
            @(negedge clk);
            #2;
            if (!rst_n) continue;
            g       = gen;
            p_req   = imem_req;
            p_rdy   = imem_ready;
            p_adv   = StallF & StallD;
            p_addr  = imem_addr;
            p_instr = InstrD;
            p_p4    = PCPlus4D;
            p_valid = ValidD;
            @(posedge clk);
            #1;
            if (!rst_n || g != gen) continue;

            if (p_req && p_rdy) begin
                if (exp_fetch.size() == 0) begin
                    check("fetch_queue_empty", 32'd1, 32'd0);
                end else begin
                    check("fetch_addr", p_addr, exp_fetch.pop_front());
                end
            end
            if (p_req && !p_rdy) check("addr_stable", imem_addr, p_addr);

            if (p_adv) begin
                if (!p_req || p_rdy) begin
                    check("deliver_valid", 32'(ValidD), 32'd1);
                    if (exp_deliv.size() == 0) begin
                        check("deliver_queue_empty", 32'd1, 32'd0);
                    end else begin
                        pc = exp_deliv.pop_front();
                        check("deliver_instr", InstrD, mem_word(pc));
                        check("deliver_pcplus4", PCPlus4D, pc + 32'd4);
                        delivered++;
                    end
                    if (exp_fetch.size() != 0) check("next_pcf", PCF, exp_fetch[0]);
                end else begin
                    check("bubble_valid", 32'(ValidD), 32'd0);
                    check("bubble_instr", InstrD, 32'd0);
                    check("bubble_pcf", PCF, p_addr);
                end
            end else begin
                check("hold_instr", InstrD, p_instr);
                check("hold_valid", 32'(ValidD), 32'(p_valid));
                check("hold_pcplus4", PCPlus4D, p_p4);
                if (p_req && p_rdy) check("held_req_low", 32'(imem_req), 32'd0);
            end
        end
    end

    // --------------------------------------------------------------- main --
    initial begin
        rst_n      = 1'b0;
        StallF     = 1'b0;
        StallD     = 1'b0;
        PCSrcD     = 1'b0;
        JumpD      = 1'b0;
        PCBranchD  = 32'd0;
        PCJumpD    = 32'd0;
        imem_ready = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check("init_pcf", PCF, RESET_PC);
        check("init_validd", 32'(ValidD), 32'd0);
        check("init_instrd", InstrD, 32'd0);
        check("init_pcplus4d", PCPlus4D, 32'd0);
        check("init_req", 32'(imem_req), 32'd0);
        @(negedge clk);
        drive_random();
        release_reset();

        for (int cyc = 0; cyc < RUN_CYCLES; cyc++) begin
            if (cyc == 700 || cyc == 1500 || cyc == 2300) begin
                reset_in_held();
            end else begin
                @(negedge clk);
                drive_random();
            end
        end

        @(negedge clk);
        check("min_deliveries", 32'(delivered >= 500), 32'd1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
